// File: rtl/integral_image_computer.sv
// rtl/integral_image_computer.sv - streaming integral image over the frame BRAM, one pixel per clock
// Optional squared-integral output enabled by defining II_SQUARED_EN.
module integral_image_computer #(
  parameter int WIDTH_ADDR  = 16,
  parameter int WIDTH_COLOR = 4,
  parameter int WIDTH_II    = 20,
  parameter int WIDTH_IMG   = 200,
  parameter int HEIGHT_IMG  = 200
) (
  input  logic                   pixel_clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic [WIDTH_ADDR-1:0]  frame_addr,
  output logic                   frame_en,
  input  logic [WIDTH_COLOR-1:0] frame_data,
  output logic [WIDTH_ADDR-1:0]  ii_addr,
  output logic [WIDTH_II-1:0]    ii_data,
  output logic                   ii_we
`ifdef II_SQUARED_EN
  ,
  output logic [23:0]            ii_sq_data
`endif
);

  localparam int XW = (WIDTH_IMG > 1) ? $clog2(WIDTH_IMG) : 1;
  localparam int YW = (HEIGHT_IMG > 1) ? $clog2(HEIGHT_IMG) : 1;
  localparam logic [XW-1:0]         X_LAST    = XW'(WIDTH_IMG - 1);
  localparam logic [WIDTH_ADDR-1:0] ADDR_LAST = WIDTH_ADDR'(WIDTH_IMG * HEIGHT_IMG - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FIN} state_t;

  state_t                state_q, state_d;
  logic [WIDTH_ADDR-1:0] frame_addr_q, frame_addr_d;
  logic                  frame_en_q, frame_en_d;
  logic [XW-1:0]         x_q, x_d;
  logic [YW-1:0]         y_q, y_d;
  logic                  drain_q, drain_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  always_comb begin
    state_d      = state_q;
    frame_addr_d = frame_addr_q;
    frame_en_d   = 1'b0;
    x_d          = x_q;
    y_d          = y_q;
    drain_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_RUN;
          frame_en_d = 1'b1;
        end
      end
      S_RUN: begin
        if (frame_addr_q == ADDR_LAST) begin
          state_d      = S_DRAIN;
          frame_addr_d = '0;
          x_d          = '0;
          y_d          = '0;
        end else begin
          frame_en_d   = 1'b1;
          frame_addr_d = frame_addr_q + 1'b1;
          if (x_q == X_LAST) begin
            x_d = '0;
            y_d = y_q + 1'b1;
          end else begin
            x_d = x_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (drain_q) state_d = S_FIN;
        else         drain_d = 1'b1;
      end
      S_FIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
    done_d = (state_d == S_FIN);
  end

  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      frame_addr_q <= '0;
      frame_en_q   <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      drain_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_addr_q <= frame_addr_d;
      frame_en_q   <= frame_en_d;
      x_q          <= x_d;
      y_q          <= y_d;
      drain_q      <= drain_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  // Stage 1: coordinates of the pixel whose BRAM data is arriving this cycle.
  logic                  s1_valid_q;
  logic [XW-1:0]         s1_x_q;
  logic [YW-1:0]         s1_y_q;
  logic [WIDTH_ADDR-1:0] s1_addr_q;
  logic [WIDTH_II-1:0]   rowsum_q, rowsum_d;
  logic [WIDTH_II-1:0]   ii_data_q, ii_d;
  logic [WIDTH_ADDR-1:0] ii_addr_q;
  logic                  ii_we_q;
  logic [WIDTH_II-1:0]   line_buf [WIDTH_IMG];
  logic [WIDTH_II-1:0]   p_ext, row_prev, above;

  always_comb begin
    p_ext    = {{(WIDTH_II-WIDTH_COLOR){1'b0}}, frame_data};
    row_prev = (s1_x_q == '0) ? '0 : rowsum_q;
    rowsum_d = row_prev + p_ext;
    // Row 0 ignores stale buffer contents, so the buffer is never cleared.
    above    = (s1_y_q == '0) ? '0 : line_buf[s1_x_q];
    ii_d     = rowsum_d + above;
  end

`ifdef II_SQUARED_EN
  logic [23:0]              rowsum_sq_q, rowsum_sq_d, ii_sq_q, ii_sq_d;
  logic [23:0]              line_buf_sq [WIDTH_IMG];
  logic [2*WIDTH_COLOR-1:0] p_wide, p_sq;
  logic [23:0]              row_prev_sq, above_sq;

  always_comb begin
    p_wide      = {{WIDTH_COLOR{1'b0}}, frame_data};
    p_sq        = p_wide * p_wide;
    row_prev_sq = (s1_x_q == '0) ? '0 : rowsum_sq_q;
    rowsum_sq_d = row_prev_sq + {{(24-2*WIDTH_COLOR){1'b0}}, p_sq};
    above_sq    = (s1_y_q == '0) ? '0 : line_buf_sq[s1_x_q];
    ii_sq_d     = rowsum_sq_d + above_sq;
  end

  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      rowsum_sq_q <= '0;
      ii_sq_q     <= '0;
    end else if (s1_valid_q) begin
      rowsum_sq_q <= rowsum_sq_d;
      ii_sq_q     <= ii_sq_d;
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (s1_valid_q) line_buf_sq[s1_x_q] <= ii_sq_d;
  end

  assign ii_sq_data = ii_sq_q;
`endif

  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_x_q     <= '0;
      s1_y_q     <= '0;
      s1_addr_q  <= '0;
      rowsum_q   <= '0;
      ii_data_q  <= '0;
      ii_addr_q  <= '0;
      ii_we_q    <= 1'b0;
    end else begin
      s1_valid_q <= frame_en_q;
      s1_x_q     <= x_q;
      s1_y_q     <= y_q;
      s1_addr_q  <= frame_addr_q;
      ii_we_q    <= s1_valid_q;
      if (s1_valid_q) begin
        rowsum_q  <= rowsum_d;
        ii_data_q <= ii_d;
        ii_addr_q <= s1_addr_q;
      end
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (s1_valid_q) line_buf[s1_x_q] <= ii_d;
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign frame_addr = frame_addr_q;
  assign frame_en   = frame_en_q;
  assign ii_addr    = ii_addr_q;
  assign ii_data    = ii_data_q;
  assign ii_we      = ii_we_q;

endmodule

// File: tb/tb_integral_image_computer.sv
// tb/tb_integral_image_computer.sv - directed checks on a full-size and a reduced-size integral image computer
module tb_integral_image_computer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int errors = 0;
  int checks = 0;
  int mode = 0;

  logic        rst = 1'b1;
  logic        f_start = 1'b0, s_start = 1'b0;
  logic        f_busy, f_done, f_fen, f_iwe, s_busy, s_done, s_fen, s_iwe;
  logic [15:0] f_faddr, f_iaddr, s_faddr, s_iaddr;
  logic [3:0]  f_fdata = 4'd0, s_fdata = 4'd0;
  logic [19:0] f_idata, s_idata;
`ifdef II_SQUARED_EN
  logic [23:0] f_sq, s_sq, f_sq_last;
`endif

  integral_image_computer dut (
    .pixel_clk(clk), .rst(rst), .start(f_start), .busy(f_busy), .done(f_done),
    .frame_addr(f_faddr), .frame_en(f_fen), .frame_data(f_fdata),
    .ii_addr(f_iaddr), .ii_data(f_idata), .ii_we(f_iwe)
`ifdef II_SQUARED_EN
    , .ii_sq_data(f_sq)
`endif
  );

  integral_image_computer #(.WIDTH_IMG(20), .HEIGHT_IMG(12)) dut_s (
    .pixel_clk(clk), .rst(rst), .start(s_start), .busy(s_busy), .done(s_done),
    .frame_addr(s_faddr), .frame_en(s_fen), .frame_data(s_fdata),
    .ii_addr(s_iaddr), .ii_data(s_idata), .ii_we(s_iwe)
`ifdef II_SQUARED_EN
    , .ii_sq_data(s_sq)
`endif
  );

  function automatic logic [3:0] pix(input int addr, input int w);
    int x;
    x = addr % w;
    case (mode)
      0:       return 4'd1;
      1:       return 4'd15;
      default: return 4'(x % 16);
    endcase
  endfunction

  always @(posedge clk) begin
    if (f_fen) f_fdata <= pix(int'(f_faddr), 200);
    if (s_fen) s_fdata <= pix(int'(s_faddr), 20);
  end

  logic [19:0] f_mem [0:39999];
  logic [19:0] s_mem [0:239];
  int f_wr = 0, f_dones = 0, s_wr = 0, s_dones = 0;
  int ref_s [0:239];

  always @(negedge clk) begin
    if (f_iwe) begin
      f_mem[f_iaddr] = f_idata;
      f_wr++;
`ifdef II_SQUARED_EN
      if (f_iaddr == 16'd39999) f_sq_last = f_sq;
`endif
    end
    if (f_done) f_dones++;
    if (s_iwe) begin
      s_mem[s_iaddr] = s_idata;
      s_wr++;
    end
    if (s_done) s_dones++;
  end

  // Reference by 2-D inclusion-exclusion over the current pattern.
  task automatic build_ref();
    for (int y = 0; y < 12; y++)
      for (int x = 0; x < 20; x++) begin
        int a;
        a = y * 20 + x;
        ref_s[a] = int'(pix(a, 20));
        if (y > 0) ref_s[a] += ref_s[a-20];
        if (x > 0) ref_s[a] += ref_s[a-1];
        if (x > 0 && y > 0) ref_s[a] -= ref_s[a-21];
      end
  endtask

  task automatic run_frame(input bit big, input int restart_at, output bit timeout, output int done_at,
                           output logic c1_busy, output logic c1_en, output logic [15:0] c1_addr);
    int c0;
    logic d;
    @(negedge clk);
    if (big) f_start = 1'b1; else s_start = 1'b1;
    c0 = cyc;
    @(negedge clk);
    f_start = 1'b0;
    s_start = 1'b0;
    c1_busy = big ? f_busy : s_busy;
    c1_en   = big ? f_fen : s_fen;
    c1_addr = big ? f_faddr : s_faddr;
    d = big ? f_done : s_done;
    while (!d && (cyc - c0) < 41000) begin
      @(negedge clk);
      if (restart_at > 0 && (cyc - c0) == restart_at) begin
        if (big) f_start = 1'b1; else s_start = 1'b1;
      end else begin
        f_start = 1'b0;
        s_start = 1'b0;
      end
      d = big ? f_done : s_done;
    end
    timeout = !d;
    done_at = cyc - c0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks += 8;
    if (s_busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got=%b exp=0", s_busy); end
    if (s_done !== 1'b0)    begin errors++; $display("FAIL reset_done got=%b exp=0", s_done); end
    if (s_fen !== 1'b0)     begin errors++; $display("FAIL reset_frame_en got=%b exp=0", s_fen); end
    if (s_faddr !== 16'd0)  begin errors++; $display("FAIL reset_frame_addr got=%0d exp=0", s_faddr); end
    if (s_iwe !== 1'b0)     begin errors++; $display("FAIL reset_ii_we got=%b exp=0", s_iwe); end
    if (s_iaddr !== 16'd0)  begin errors++; $display("FAIL reset_ii_addr got=%0d exp=0", s_iaddr); end
    if (s_idata !== 20'd0)  begin errors++; $display("FAIL reset_ii_data got=%0d exp=0", s_idata); end
    if (f_busy !== 1'b0)    begin errors++; $display("FAIL reset_full_busy got=%b exp=0", f_busy); end
    rst = 1'b0;
  endtask

  task automatic test_full_frame();
    bit to; int da; logic cb, ce; logic [15:0] ca; logic busy_at_done; int bad;
    mode = 1; f_wr = 0; f_dones = 0;
    run_frame(1'b1, 100, to, da, cb, ce, ca);
    busy_at_done = f_busy;
    checks += 6;
    if (to !== 1'b0)          begin errors++; $display("FAIL full_timeout got=%b exp=0", to); end
    if (cb !== 1'b1)          begin errors++; $display("FAIL full_c1_busy got=%b exp=1", cb); end
    if (ce !== 1'b1)          begin errors++; $display("FAIL full_c1_frame_en got=%b exp=1", ce); end
    if (ca !== 16'd0)         begin errors++; $display("FAIL full_c1_frame_addr got=%0d exp=0", ca); end
    if (da != 40003)          begin errors++; $display("FAIL full_done_cycle got=%0d exp=40003", da); end
    if (busy_at_done !== 1'b0) begin errors++; $display("FAIL full_busy_at_done got=%b exp=0", busy_at_done); end
    repeat (5) @(negedge clk);
    checks += 7;
    if (f_wr != 40000)        begin errors++; $display("FAIL full_write_count got=%0d exp=40000", f_wr); end
    if (f_dones != 1)         begin errors++; $display("FAIL full_done_count got=%0d exp=1", f_dones); end
    if (f_fen !== 1'b0)       begin errors++; $display("FAIL full_idle_frame_en got=%b exp=0", f_fen); end
    if (f_mem[39999] !== 20'd600000) begin errors++; $display("FAIL full_ii_39999 got=%0d exp=600000", f_mem[39999]); end
    if (f_mem[200] !== 20'd30)       begin errors++; $display("FAIL full_ii_200 got=%0d exp=30", f_mem[200]); end
    if (f_mem[199] !== 20'd3000)     begin errors++; $display("FAIL full_ii_199 got=%0d exp=3000", f_mem[199]); end
    bad = 0;
    for (int a = 0; a < 40000; a++)
      if (f_mem[a] !== 20'(15 * (a % 200 + 1) * (a / 200 + 1))) bad++;
    if (bad != 0)             begin errors++; $display("FAIL full_scan got=%0d bad exp=0", bad); end
`ifdef II_SQUARED_EN
    checks++;
    if (f_sq_last !== 24'd9000000) begin errors++; $display("FAIL full_sq_39999 got=%0d exp=9000000", f_sq_last); end
`endif
  endtask

  task automatic test_ones_small();
    bit to; int da; logic cb, ce; logic [15:0] ca; int bad;
    mode = 0; s_wr = 0; s_dones = 0;
    build_ref();
    run_frame(1'b0, 0, to, da, cb, ce, ca);
    repeat (5) @(negedge clk);
    bad = 0;
    for (int a = 0; a < 240; a++) if (s_mem[a] !== 20'((a % 20 + 1) * (a / 20 + 1))) bad++;
    checks += 7;
    if (to !== 1'b0)           begin errors++; $display("FAIL ones_timeout got=%b exp=0", to); end
    if (da != 243)             begin errors++; $display("FAIL ones_done_cycle got=%0d exp=243", da); end
    if (s_mem[239] !== 20'd240) begin errors++; $display("FAIL ones_ii_239 got=%0d exp=240", s_mem[239]); end
    if (s_mem[19] !== 20'd20)   begin errors++; $display("FAIL ones_ii_19 got=%0d exp=20", s_mem[19]); end
    if (bad != 0)              begin errors++; $display("FAIL ones_scan got=%0d bad exp=0", bad); end
    if (s_wr != 240)           begin errors++; $display("FAIL ones_write_count got=%0d exp=240", s_wr); end
    if (s_dones != 1)          begin errors++; $display("FAIL ones_done_count got=%0d exp=1", s_dones); end
  endtask

  task automatic test_ramp_small();
    bit to; int da; logic cb, ce; logic [15:0] ca; int bad, pbad, run;
    mode = 2; s_wr = 0; s_dones = 0;
    build_ref();
    run_frame(1'b0, 0, to, da, cb, ce, ca);
    repeat (3) @(negedge clk);
    run = 0; pbad = 0;
    for (int x = 0; x < 20; x++) begin
      run += x % 16;
      if (s_mem[x] !== 20'(run)) pbad++;
    end
    bad = 0;
    for (int a = 0; a < 240; a++) if (s_mem[a] !== 20'(ref_s[a])) bad++;
    checks += 5;
    if (to !== 1'b0)          begin errors++; $display("FAIL ramp_timeout got=%b exp=0", to); end
    if (pbad != 0)            begin errors++; $display("FAIL ramp_row0_prefix got=%0d bad exp=0", pbad); end
    if (s_mem[19] !== 20'd126) begin errors++; $display("FAIL ramp_ii_19 got=%0d exp=126", s_mem[19]); end
    if (s_mem[39] !== 20'd252) begin errors++; $display("FAIL ramp_ii_39 got=%0d exp=252", s_mem[39]); end
    if (bad != 0)             begin errors++; $display("FAIL ramp_scan got=%0d bad exp=0", bad); end
  endtask

  task automatic test_reset_midframe();
    bit to; int da; logic cb, ce; logic [15:0] ca; int bad, w0;
    mode = 1; s_wr = 0; s_dones = 0;
    @(negedge clk); s_start = 1'b1;
    @(negedge clk); s_start = 1'b0;
    repeat (99) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks += 2;
    if (s_iwe !== 1'b0)  begin errors++; $display("FAIL abort_ii_we got=%b exp=0", s_iwe); end
    if (s_busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", s_busy); end
    w0 = s_wr;
    repeat (300) @(negedge clk);
    checks += 2;
    if (s_dones != 0)    begin errors++; $display("FAIL abort_no_done got=%0d exp=0", s_dones); end
    if (s_wr != w0)      begin errors++; $display("FAIL abort_no_writes got=%0d exp=%0d", s_wr, w0); end
    for (int a = 0; a < 240; a++) s_mem[a] = 'x;
    mode = 2; s_wr = 0;
    build_ref();
    run_frame(1'b0, 0, to, da, cb, ce, ca);
    repeat (3) @(negedge clk);
    bad = 0;
    for (int a = 0; a < 240; a++) if (s_mem[a] !== 20'(ref_s[a])) bad++;
    checks += 3;
    if (to !== 1'b0)     begin errors++; $display("FAIL rerun_timeout got=%b exp=0", to); end
    if (bad != 0)        begin errors++; $display("FAIL rerun_scan got=%0d bad exp=0", bad); end
    if (s_dones != 1)    begin errors++; $display("FAIL rerun_done_count got=%0d exp=1", s_dones); end
  endtask

  task automatic test_back_to_back();
    bit to1, to2; int da1, da2; logic cb, ce; logic [15:0] ca; int bad;
    mode = 0; s_wr = 0; s_dones = 0;
    run_frame(1'b0, 0, to1, da1, cb, ce, ca);
    mode = 2;
    build_ref();
    run_frame(1'b0, 0, to2, da2, cb, ce, ca);
    repeat (5) @(negedge clk);
    bad = 0;
    for (int a = 0; a < 240; a++) if (s_mem[a] !== 20'(ref_s[a])) bad++;
    checks += 7;
    if (to1 !== 1'b0 || to2 !== 1'b0) begin errors++; $display("FAIL b2b_timeout got=%b%b exp=00", to1, to2); end
    if (da2 != 243)      begin errors++; $display("FAIL b2b_done_cycle got=%0d exp=243", da2); end
    if (cb !== 1'b1)     begin errors++; $display("FAIL b2b_c1_busy got=%b exp=1", cb); end
    if (ca !== 16'd0)    begin errors++; $display("FAIL b2b_c1_frame_addr got=%0d exp=0", ca); end
    if (s_wr != 480)     begin errors++; $display("FAIL b2b_write_count got=%0d exp=480", s_wr); end
    if (s_dones != 2)    begin errors++; $display("FAIL b2b_done_count got=%0d exp=2", s_dones); end
    if (bad != 0)        begin errors++; $display("FAIL b2b_scan got=%0d bad exp=0", bad); end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_ones_small();
    test_ramp_small();
    test_reset_midframe();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/integral_image_computer.md
# integral_image_computer

Computes the integral image of the 200x200, 4-bit grayscale frame stored in frame BRAM by the imager interface, and writes one 20-bit integral value per pixel into the integral BRAM read by the Haar-feature stage. It is the stage directly downstream of the imager interface. It starts on the imager's `done` pulse and streams one pixel per clock in raster order. It reports completion with a one-cycle `done` pulse back to the CPU.

## Interface
- `WIDTH_ADDR`, 16: frame and integral BRAM address width
- `WIDTH_COLOR`, 4: pixel width
- `WIDTH_II`, 20: integral value width (max 200·200·15 = 600000 < 2^20)
- `WIDTH_IMG`, 200: frame width in pixels
- `HEIGHT_IMG`, 200: frame height in pixels

Ports:
- `pixel_clk`  in  1  sole clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle pulse; starts one frame
- `busy`  out  1  high while a frame is in progress
- `done`  out  1  one-cycle pulse after the last integral write
- `frame_addr`  out  WIDTH_ADDR  frame BRAM read address
- `frame_en`  out  1  frame BRAM read enable
- `frame_data`  in  WIDTH_COLOR  frame BRAM read data; 1-cycle read latency
- `ii_addr`  out  WIDTH_ADDR  integral BRAM write address
- `ii_data`  out  WIDTH_II  integral value
- `ii_we`  out  1  integral BRAM write strobe (also drives its enable)

## Operation
- Definition: II(x,y) = sum of p(i,j) for i≤x, j≤y.
- Recurrence: rowsum(x,y) = rowsum(x−1,y) + p(x,y), with rowsum = 0 before x = 0. II(x,y) = rowsum(x,y) + II(x,y−1), with II(x,−1) = 0.
- Line buffer: internal array of WIDTH_IMG × WIDTH_II words holding II of the previous row, indexed by x.
  - Each cycle reads `line_buf[x]` and writes back the new II(x,y).
  - When y = 0 the read value is forced to 0, so the buffer never needs clearing.
- Address equals x + y·WIDTH_IMG. It is generated by an incrementing counter, not a multiplier.
- x and y counters advance together. x wraps from 199 to 0 and increments y. The stage-1 x/y copies travel with the data.
- FSM states:
  - IDLE: counters are 0. `start` moves to RUN.
  - RUN: issues one read per cycle. After issuing address 39999 → DRAIN.
  - DRAIN: waits 2 cycles for the pipeline to empty → FIN.
  - FIN: pulses `done` for one cycle → IDLE.
- `start` is ignored outside IDLE.
- Arithmetic is unsigned. Sums are exact at WIDTH_II, with no saturation or wrap for legal inputs. `p` is zero-extended.
- Reset values: `busy`=0, `done`=0, `frame_en`=0, `frame_addr`=0, `ii_we`=0, `ii_addr`=0, `ii_data`=0, state IDLE, counters 0, rowsum 0.
- Reset mid-frame:
  - Aborts on the next edge. `ii_we` is 0 from that edge on. No `done` pulse is issued.
  - Partially written integral BRAM contents are undefined.
  - A fresh `start` recomputes the whole frame.

## Timing
- Cycle 0: `start`=1 in IDLE.
- Cycle 1: `busy`=1, `frame_en`=1, `frame_addr`=0.
- Pixel n is read at cycle 1+n and written at cycle 3+n, with `ii_we`=1 and `ii_addr`=n. Latency is 2 cycles and throughput is 1 pixel/cycle.
- Last write is at cycle 40002. `done`=1 at cycle 40003, and `busy` falls in the same cycle.
- IDLE is reached at cycle 40004. The earliest accepted next `start` is at cycle 40004.
- `frame_en`=0 outside RUN. `ii_we` is never asserted in IDLE or FIN.
- All outputs are registered.

## Configuration
- `II_SQUARED_EN`:
  - When defined, adds output `ii_sq_data` (24 bits) carrying the squared integral. It uses p² in place of p with the same recurrence and a second line buffer. Max value is 200·200·225 = 9,000,000 < 2^24.
  - The squared value is written with the same `ii_we`/`ii_addr` as `ii_data`, for variance normalisation downstream.
  - When undefined, the port, the second buffer and the squarer are absent. All other behaviour is identical.

## Test plan
- All pixels = 1, pulse `start` → each write has `ii_data` = (x+1)(y+1). Address 39999 = 40000 and address 199 = 200. `done` occurs at cycle 40003.
- All pixels = 15 → address 39999 = 600000 and address 200 (x=0,y=1) = 30. No overflow.
- Ramp p = x mod 16 → row 0 values match the prefix sums. The value at address 399 equals twice the value at address 199, checked against a reference model.
- `start` re-pulsed at cycle 100 → ignored. The write count is exactly 40000 and there is one `done`.
- `rst` at cycle 5000, then `start` → no `done` after the reset. The second run produces correct values for all 40000 addresses.
- With `II_SQUARED_EN` and all pixels = 15 → `ii_sq_data` at address 39999 = 9,000,000. Without the macro, `ii_data` is unchanged.
